// File: rtl/sha_256_stream.sv
// sha_256_stream: multi-block SHA-256/SHA-224 compression engine, one round per clock.
// Pre-padded 512-bit blocks arrive over valid/ready; the hash state chains across the blocks of a message.
module sha_256_stream #(
    parameter int MSG_SIZ   = 512,
    parameter int MSG_BLK   = 32,
    parameter int MAX_CNT   = 63,
    parameter int HASH_SIZE = 256
) (
    input  logic                 usr_clk,
    input  logic                 usr_reset,
    input  logic                 i_valid,
    input  logic                 i_first,
    input  logic                 i_last,
    input  logic                 i_mode,
    input  logic [MSG_SIZ-1:0]   i_msg,
    output logic                 o_ready,
    output logic                 o_valid,
    output logic [HASH_SIZE-1:0] o_hash
);
    localparam int CNT_W = $clog2(MAX_CNT + 1);
    localparam int N_WIN = MSG_SIZ / MSG_BLK;

    typedef logic [MSG_BLK-1:0] word_t;
    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_UPDATE} state_t;

    localparam word_t IV_256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam word_t IV_224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (MSG_BLK - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t               state, next_state;
    logic                 accept, do_round, do_update;
    logic [CNT_W-1:0]     cnt;
    logic                 mode_q, last_q;
    word_t                hv [8];
    word_t                w_win [N_WIN];
    word_t                a, b, c, d, e, f, g, h;
    word_t                t1, t2, w_next;
    word_t                work [8];
    word_t                init_v [8];
    word_t                hv_sum [8];
    logic [HASH_SIZE-1:0] digest;

    always_ff @(posedge usr_clk or posedge usr_reset) begin
        if (usr_reset) state <= S_IDLE;
        else           state <= next_state;
    end

    // NOTE: every combinational output gets a default first so no path through the block can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (accept) next_state = S_ROUND;
            S_ROUND:  if (cnt == CNT_W'(MAX_CNT)) next_state = S_UPDATE;
            S_UPDATE: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        accept    = 1'b0;
        do_round  = 1'b0;
        do_update = 1'b0;
        case (state)
            S_IDLE:   accept    = i_valid & o_ready;
            S_ROUND:  do_round  = 1'b1;
            S_UPDATE: do_update = 1'b1;
            default:  ;
        endcase
    end

    // One compression round, the next schedule word, and the block-end feed-forward sums.
    always_comb begin
        t1     = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + K[cnt] + w_win[0];
        t2     = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));
        w_next = small_sigma1(w_win[14]) + w_win[9] + small_sigma0(w_win[1]) + w_win[0];
        work   = '{a, b, c, d, e, f, g, h};
        digest = '0;
        for (int i = 0; i < 8; i++) begin
            init_v[i] = i_first ? (i_mode ? IV_256[i] : IV_224[i]) : hv[i];
            hv_sum[i] = hv[i] + work[i];
            digest[HASH_SIZE-1-MSG_BLK*i -: MSG_BLK] = hv_sum[i];
        end
        if (!mode_q) digest[MSG_BLK-1:0] = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge usr_clk or posedge usr_reset) begin
        if (usr_reset) begin
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_hash  <= '0;
            hv      <= IV_256;
            mode_q  <= 1'b1;
            last_q  <= 1'b0;
            cnt     <= '0;
        end else begin
            o_ready <= (next_state == S_IDLE);
            o_valid <= do_update & last_q;
            if (accept) begin
                cnt    <= '0;
                last_q <= i_last;
                if (i_first) begin
                    mode_q <= i_mode;
                    hv     <= i_mode ? IV_256 : IV_224;
                end
            end else if (do_round) begin
                cnt <= cnt + 1'b1;
            end else if (do_update) begin
                hv <= hv_sum;
                if (last_q) o_hash <= digest;
            end
        end
    end

    // NOTE: the message window and a..h are not reset: both are fully reloaded on every accepted block.
    always_ff @(posedge usr_clk) begin
        if (accept) begin
            for (int i = 0; i < N_WIN; i++)
                w_win[i] <= i_msg[MSG_SIZ-1-MSG_BLK*i -: MSG_BLK];
            a <= init_v[0]; b <= init_v[1]; c <= init_v[2]; d <= init_v[3];
            e <= init_v[4]; f <= init_v[5]; g <= init_v[6]; h <= init_v[7];
        end else if (do_round) begin
            for (int i = 0; i < N_WIN-1; i++)
                w_win[i] <= w_win[i+1];
            w_win[N_WIN-1] <= w_next;
            h <= g; g <= f; f <= e; e <= d + t1;
            d <= c; c <= b; b <= a; a <= t1 + t2;
        end
    end

endmodule

// File: tb/tb_sha_256_stream.sv
// tb_sha_256_stream: directed known-answer vectors plus random multi-block messages
// scored against a whole-block SHA-256 reference model.
module tb_sha_256_stream;
    typedef logic [255:0] val_t;
    typedef struct {
        val_t digest;
        int   due;
    } exp_t;

    localparam logic [511:0] ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] T3_B1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] T3_B2 = {480'h0, 32'h000001c0};
    localparam val_t D_ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam val_t D_ABC224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
    localparam val_t D_T3     = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [31:0] K_TB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic         usr_clk = 1'b0;
    logic         usr_reset = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_first = 1'b0;
    logic         i_last = 1'b0;
    logic         i_mode = 1'b0;
    logic [511:0] i_msg = '0;
    logic         o_ready;
    logic         o_valid;
    logic [255:0] o_hash;

    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    exp_t exp_q [$];
    val_t m_h;
    logic m_mode;

    sha_256_stream dut (
        .usr_clk  (usr_clk),
        .usr_reset(usr_reset),
        .i_valid  (i_valid),
        .i_first  (i_first),
        .i_last   (i_last),
        .i_mode   (i_mode),
        .i_msg    (i_msg),
        .o_ready  (o_ready),
        .o_valid  (o_valid),
        .o_hash   (o_hash)
    );

    initial forever #5 usr_clk = ~usr_clk;
    always @(posedge usr_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input val_t got, input val_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic val_t iv_of(input logic mode);
        return mode ? 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19
                    : 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
    endfunction

    // Whole-block compression: full 64-word schedule expanded up front, state kept as an array.
    function automatic val_t sha_compress(input val_t hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        val_t        r;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0   = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TB[t] + w[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return r;
    endfunction

    function automatic logic [511:0] rand_blk();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_accept(input logic [511:0] blk, input logic first, input logic last, input logic mode);
        exp_t x;
        if (first) begin
            m_h    = iv_of(mode);
            m_mode = mode;
        end
        m_h = sha_compress(m_h, blk);
        if (last) begin
            x.digest = m_mode ? m_h : {m_h[255:32], 32'h0};
            x.due    = cyc + 65;
            exp_q.push_back(x);
        end
    endtask

    // Presents a block, waits for o_ready, and returns after the accepting edge; n = cycles spent waiting.
    task automatic send_block(input logic [511:0] blk, input logic first, input logic last,
                              input logic mode, input logic hold, output int n);
        @(negedge usr_clk);
        i_valid = 1'b1; i_msg = blk; i_first = first; i_last = last; i_mode = mode;
        n = 0;
        while (!o_ready && n < 200) begin
            @(negedge usr_clk);
            n++;
        end
        if (!o_ready) begin
            check("accept_timeout", 256'(o_ready), 256'(1));
            i_valid = 1'b0;
            return;
        end
        @(posedge usr_clk);
        #1;
        model_accept(blk, first, last, mode);
        if (!hold) i_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        @(negedge usr_clk);
        while (!o_ready && n < 200) begin
            n++;
            @(negedge usr_clk);
        end
    endtask

    // Garbage on the inputs while the engine is busy; stops presenting once o_ready returns.
    task automatic garbage_while_busy(output int n);
        n = 0;
        while (n < 200) begin
            @(negedge usr_clk);
            if (o_ready) break;
            i_valid = 1'($urandom);
            i_first = 1'($urandom);
            i_last  = 1'($urandom);
            i_mode  = 1'($urandom);
            i_msg   = rand_blk();
            n++;
        end
        i_valid = 1'b0;
    endtask

    task automatic reset_pulse(input string tag);
        usr_reset = 1'b1;
        i_valid   = 1'b0;
        #1;
        check({tag, "_ready"}, 256'(o_ready), 256'(1));
        check({tag, "_valid"}, 256'(o_valid), 256'(0));
        check({tag, "_hash"}, o_hash, '0);
        exp_q.delete();
        m_h    = iv_of(1'b1);
        m_mode = 1'b1;
        repeat (2) @(negedge usr_clk);
        usr_reset = 1'b0;
    endtask

    // Scoreboard: every o_valid pulse must match the oldest pending digest at its due cycle.
    always @(negedge usr_clk) begin
        exp_t x;
        if (!usr_reset && o_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 256'(o_valid), 256'(0));
            end else begin
                x = exp_q.pop_front();
                check("digest", o_hash, x.digest);
                check("latency", 256'(cyc), 256'(x.due));
            end
        end
    end

    initial begin
        int n;
        int nb;
        logic mode;
        logic hold;
        #2;
        reset_pulse("reset");

        send_block(ABC, 1'b1, 1'b1, 1'b1, 1'b0, n);
        wait_ready(n);
        check("abc256_busy", 256'(n), 256'(65));
        check("abc256", o_hash, D_ABC256);

        send_block(ABC, 1'b1, 1'b1, 1'b0, 1'b0, n);
        wait_ready(n);
        check("abc224", o_hash, D_ABC224);

        send_block(T3_B1, 1'b1, 1'b0, 1'b1, 1'b0, n);
        wait_ready(n);
        check("t3_hold_after_b1", o_hash, D_ABC224);
        send_block(T3_B2, 1'b0, 1'b1, 1'b0, 1'b0, n);
        wait_ready(n);
        check("t3_two_block", o_hash, D_T3);

        send_block(ABC, 1'b1, 1'b1, 1'b1, 1'b1, n);
        send_block(T3_B1, 1'b1, 1'b0, 1'b1, 1'b1, n);
        check("b2b_busy1", 256'(n), 256'(65));
        send_block(T3_B2, 1'b0, 1'b1, 1'b1, 1'b0, n);
        check("b2b_busy2", 256'(n), 256'(65));
        wait_ready(n);
        check("b2b_t3", o_hash, D_T3);

        send_block(ABC, 1'b1, 1'b1, 1'b1, 1'b0, n);
        repeat (30) @(posedge usr_clk);
        #2;
        reset_pulse("midround_reset");
        send_block(ABC, 1'b1, 1'b1, 1'b1, 1'b0, n);
        wait_ready(n);
        check("abc_after_reset", o_hash, D_ABC256);

        send_block(ABC, 1'b1, 1'b1, 1'b1, 1'b0, n);
        garbage_while_busy(n);
        check("garbage_busy", 256'(n), 256'(65));
        check("abc_with_garbage", o_hash, D_ABC256);
        send_block(T3_B1, 1'b1, 1'b0, 1'b1, 1'b0, n);
        garbage_while_busy(n);
        send_block(T3_B2, 1'b0, 1'b1, 1'b1, 1'b0, n);
        wait_ready(n);
        check("t3_with_garbage", o_hash, D_T3);

        for (int m = 0; m < 10; m++) begin
            nb   = 1 + int'($urandom_range(2));
            mode = 1'($urandom);
            for (int blk = 0; blk < nb; blk++) begin
                hold = 1'($urandom);
                send_block(rand_blk(), blk == 0, blk == nb - 1,
                           (blk == 0) ? mode : 1'($urandom), hold, n);
                if (!hold) repeat ($urandom_range(3)) @(negedge usr_clk);
            end
        end
        @(negedge usr_clk);
        i_valid = 1'b0;

        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge usr_clk);
            n++;
        end
        check("scoreboard_drain", 256'(exp_q.size()), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
